// File: rtl/csv_pkg.sv
// rtl/csv_pkg.sv - shared types and ASCII constants for the CSV tokenizer
package csv_pkg;

  typedef enum logic [1:0] {
    K_DATA = 2'd0,
    K_EOF  = 2'd1,
    K_EOR  = 2'd2
  } kind_e;

  // E_NONE keeps err_code at 0 out of reset; only the other codes are ever pulsed.
  typedef enum logic [1:0] {
    E_NONE      = 2'd0,
    E_BAD_QUOTE = 2'd1,
    E_COL_OVF   = 2'd2,
    E_EOS_QUOTE = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    S_FSTART = 3'd0,
    S_UNQ    = 3'd1,
    S_QUOTED = 3'd2,
    S_QSEEN  = 3'd3,
    S_SKIP   = 3'd4,
    S_FLUSH  = 3'd5
  } state_e;

  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;

endpackage

// File: rtl/csv_tokenizer_ctrl.sv
// rtl/csv_tokenizer_ctrl.sv - byte-stream CSV tokenizer emitting data/field/record beats
// One registered output stage; decode of each accepted byte is purely combinational.
module csv_tokenizer_ctrl
  import csv_pkg::*;
#(
  parameter int         MAX_COLS = 16,
  parameter int         ROW_W    = 16,
  parameter logic [7:0] SEP      = 8'h2C,
  parameter logic [7:0] QUOTE    = 8'h22,
  localparam int        CW       = $clog2(MAX_COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output kind_e            out_kind,
  output logic [7:0]       out_data,
  output logic [CW-1:0]    out_col,
  output logic [ROW_W-1:0] out_row,
  output logic             err_valid,
  output err_e             err_code
);

  localparam logic [CW-1:0]    COL_MAX = CW'(MAX_COLS - 1);
  localparam logic [CW-1:0]    COL_ONE = CW'(1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

  state_e             state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               out_valid_q, out_valid_d;
  kind_e              out_kind_q, out_kind_d;
  logic [7:0]         out_data_q, out_data_d;
  logic [CW-1:0]      out_col_q, out_col_d;
  logic [ROW_W-1:0]   out_row_q, out_row_d;
  logic               err_valid_q, err_valid_d;
  err_e               err_code_q, err_code_d;

  logic               slot_free;
  logic               accept;
  logic               beat;
  kind_e              beat_kind;
  logic [7:0]         beat_data;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q != S_FLUSH) && slot_free;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q && !out_ready;
    out_kind_d  = out_kind_q;
    out_data_d  = out_data_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    beat        = 1'b0;
    beat_kind   = K_DATA;
    beat_data   = 8'h00;

    if (state_q == S_FLUSH) begin
      if (slot_free) begin
        beat      = 1'b1;
        beat_kind = K_EOR;
        state_d   = S_FSTART;
        col_d     = '0;
        row_d     = '0;
      end
    end else if (accept) begin
      unique case (state_q)
        S_QUOTED: begin
          if (in_data == QUOTE) begin
            state_d = S_QSEEN;
          end else begin
            beat      = 1'b1;
            beat_data = in_data;
          end
        end
        S_SKIP: begin
          if (in_data == LF) begin
            col_d   = '0;
            row_d   = row_q + ROW_ONE;
            state_d = S_FSTART;
          end
        end
        default: begin
          // FSTART, UNQ and QSEEN share the separator/terminator handling.
          if (state_q == S_QSEEN && in_data == QUOTE) begin
            beat      = 1'b1;
            beat_data = QUOTE;
            state_d   = S_QUOTED;
          end else if (state_q == S_FSTART && in_data == QUOTE) begin
            state_d = S_QUOTED;
          end else if (in_data == SEP) begin
            if (col_q == COL_MAX) begin
              err_valid_d = 1'b1;
              err_code_d  = E_COL_OVF;
              state_d     = S_SKIP;
            end else begin
              beat      = 1'b1;
              beat_kind = K_EOF;
              col_d     = col_q + COL_ONE;
              state_d   = S_FSTART;
            end
          end else if (in_data == LF) begin
            if (!(state_q == S_FSTART && col_q == '0)) begin
              beat      = 1'b1;
              beat_kind = K_EOR;
              col_d     = '0;
              row_d     = row_q + ROW_ONE;
            end
            state_d = S_FSTART;
          end else if (in_data == CR) begin
            if (state_q == S_QSEEN) state_d = S_UNQ;
          end else if (state_q == S_QSEEN) begin
            err_valid_d = 1'b1;
            err_code_d  = E_BAD_QUOTE;
            state_d     = S_SKIP;
          end else begin
            beat      = 1'b1;
            beat_data = in_data;
            state_d   = S_UNQ;
          end
        end
      endcase

      // A field still open at end of stream gets a closing EOR via FLUSH.
      if (in_last) begin
        if (state_d == S_UNQ || state_d == S_QSEEN || (state_d == S_FSTART && col_d != '0)) begin
          state_d = S_FLUSH;
        end else begin
          if (state_d == S_QUOTED) begin
            err_valid_d = 1'b1;
            err_code_d  = E_EOS_QUOTE;
          end
          state_d = S_FSTART;
          col_d   = '0;
          row_d   = '0;
        end
      end
    end

    if (beat) begin
      out_valid_d = 1'b1;
      out_kind_d  = beat_kind;
      out_data_d  = beat_data;
      out_col_d   = col_q;
      out_row_d   = row_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FSTART;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_kind_q  <= K_DATA;
      out_data_q  <= 8'h00;
      out_col_q   <= '0;
      out_row_q   <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= E_NONE;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_kind_q  <= out_kind_d;
      out_data_q  <= out_data_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_kind  = out_kind_q;
  assign out_data  = out_data_q;
  assign out_col   = out_col_q;
  assign out_row   = out_row_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_csv_tokenizer_ctrl.sv
// tb/tb_csv_tokenizer_ctrl.sv - randomized bench against a stream-level CSV reference model
module tb_csv_tokenizer_ctrl;
  import csv_pkg::*;

  localparam int MAXC  = 4;
  localparam int CW    = 2;
  localparam int ROW_W = 16;

  typedef logic [7:0] bq_t[$];

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last;
  logic [7:0]       in_data;
  logic             out_valid, out_ready;
  kind_e            out_kind;
  logic [7:0]       out_data;
  logic [CW-1:0]    out_col;
  logic [ROW_W-1:0] out_row;
  logic             err_valid;
  err_e             err_code;

  csv_tokenizer_ctrl #(.MAX_COLS(MAXC), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_data(out_data), .out_col(out_col), .out_row(out_row),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          stall_cnt;
  logic [27:0] got_b[$];
  logic [27:0] exp_b[$];
  logic [1:0]  got_e[$];
  logic [1:0]  exp_e[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] pack_out();
    return {out_kind, out_data, out_col, out_row};
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic emit(input logic [1:0] k, input logic [7:0] d, input int c, input int r);
    exp_b.push_back({k, d, 2'(c), 16'(r)});
  endtask

  // Reference: tokenizes a whole in_last-terminated stream using field-level flags.
  task automatic model(input bq_t s);
    int row, col;
    bit inq, qpend, closed, infield, skip;
    logic [7:0] b;
    row = 0; col = 0; inq = 0; qpend = 0; closed = 0; infield = 0; skip = 0;
    exp_b.delete();
    exp_e.delete();
    foreach (s[i]) begin
      b = s[i];
      if (skip) begin
        if (b == 8'h0A) begin row++; col = 0; skip = 0; end
        continue;
      end
      if (inq) begin
        if (!qpend) begin
          if (b == 8'h22) qpend = 1;
          else emit(K_DATA, b, col, row);
          continue;
        end
        qpend = 0;
        if (b == 8'h22) begin emit(K_DATA, 8'h22, col, row); continue; end
        inq = 0; closed = 1;
      end
      if (b == 8'h2C) begin
        if (col == MAXC - 1) begin exp_e.push_back(E_COL_OVF); skip = 1; end
        else begin emit(K_EOF, 8'h00, col, row); col++; end
        infield = 0; closed = 0;
      end else if (b == 8'h0A) begin
        if (infield || closed || col > 0) begin emit(K_EOR, 8'h00, col, row); col = 0; row++; end
        infield = 0; closed = 0;
      end else if (b == 8'h0D) begin
        closed = 0;
      end else if (closed) begin
        exp_e.push_back(E_BAD_QUOTE); skip = 1; closed = 0; infield = 0;
      end else if (b == 8'h22 && !infield) begin
        inq = 1; infield = 1;
      end else begin
        emit(K_DATA, b, col, row); infield = 1;
      end
    end
    if (inq && !qpend) exp_e.push_back(E_EOS_QUOTE);
    else if (!skip && (inq || infield || closed || col > 0)) emit(K_EOR, 8'h00, col, row);
  endtask

  task automatic run(input bq_t s, input bit last, input int vpct, input int rpct);
    int idx, cyc, drain;
    bit hold, stalled;
    logic [27:0] snap;
    idx = 0; cyc = 0; drain = 0; hold = 0; stalled = 0; snap = '0;
    got_b.delete();
    got_e.delete();
    stall_cnt = 0;
    while (drain < 8) begin
      @(posedge clk); #1;
      if (idx < s.size()) begin
        if (hold || $urandom_range(99) < vpct) begin
          in_valid = 1'b1;
          in_data  = s[idx];
          in_last  = last && (idx == s.size() - 1);
          hold     = 1;
        end else begin
          in_valid = 1'b0;
          in_last  = 1'b0;
        end
        out_ready = ($urandom_range(99) < rpct);
      end else begin
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        drain++;
      end
      @(negedge clk);
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_beat", pack_out(), snap);
      end
      stalled = out_valid && !out_ready;
      snap    = pack_out();
      if (out_valid && out_ready) got_b.push_back(pack_out());
      if (err_valid) got_e.push_back(err_code);
      if (in_valid && !in_ready) stall_cnt++;
      if (in_valid && in_ready) begin idx++; hold = 0; end
      if (++cyc > 5000) begin
        chk("timeout_idx", idx, s.size());
        break;
      end
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, "_nbeats"}, got_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) chk({tag, "_beat"}, got_b[i], exp_b[i]);
    chk({tag, "_nerrs"}, got_e.size(), exp_e.size());
    for (int i = 0; i < exp_e.size() && i < got_e.size(); i++) chk({tag, "_err"}, got_e[i], exp_e[i]);
  endtask

  task automatic directed(input string tag, input string txt, input int rpct);
    bq_t q;
    q = str2q(txt);
    model(q);
    run(q, 1, 100, rpct);
    compare(tag);
  endtask

  initial begin
    bq_t q;
    string alpha;
    int n;
    alpha     = "ab7,,\"\"\n\r";
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_beat", pack_out(), 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_in_ready", in_ready, 1);

    directed("t1", "a,b\n", 100);
    chk("t1_stalls", stall_cnt, 0);
    chk("t1_first", got_b.size() > 0 ? got_b[0] : 28'hfffffff, {K_DATA, 8'h61, 2'd0, 16'd0});
    directed("t2", "\"x\"\"y\",\n", 100);
    directed("t3", "\"ab\"c,1\n2\n", 100);
    directed("t4", "1,2,3,4,5\n", 100);
    directed("t5", "ab", 25);
    directed("t5b", "a,", 40);
    directed("t5c", "\"ab", 60);

    q = str2q("\"abc");
    run(q, 0, 100, 100);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", out_valid, 0);
    directed("t6", "z\n", 100);

    for (int t = 0; t < 60; t++) begin
      q.delete();
      n = $urandom_range(24, 1);
      for (int i = 0; i < n; i++) q.push_back(alpha[$urandom_range(alpha.len() - 1)]);
      model(q);
      run(q, 1, $urandom_range(100, 50), $urandom_range(100, 30));
      compare("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
